// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, parity modes and frame defaults
// Used by both the transmitter and the receiver so the state codes and
// parity-mode values agree across the link.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  localparam int unsigned DEF_NDATA_BITS   = 8;
  localparam int unsigned DEF_NSTOP_BITS   = 1;
  localparam int unsigned DEF_OVERSAMPLING = 16;
  localparam int unsigned DEF_PARITY_MODE  = PARITY_NONE;

endpackage

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART frame serialiser driven by the oversampled baud tick
// Ports:
//   i_clock    - system clock, posedge
//   i_reset    - asynchronous active-low reset
//   i_baud     - one-clock tick at OVERSAMPLING x bit rate
//   i_tx_start - send request, only honoured while idle
//   i_data     - word to send, captured on accept
//   o_tx       - registered serial line, idle high
//   o_busy     - high whenever a frame is in progress
//   o_tx_done  - one-clock pulse after the last stop bit
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned NDATA_BITS   = DEF_NDATA_BITS,
  parameter int unsigned NSTOP_BITS   = DEF_NSTOP_BITS,
  parameter int unsigned OVERSAMPLING = DEF_OVERSAMPLING,
  parameter int unsigned PARITY_MODE  = DEF_PARITY_MODE
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_baud,
  input  logic                  i_tx_start,
  input  logic [NDATA_BITS-1:0] i_data,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_tx_done
);

  localparam int unsigned TICK_W = (OVERSAMPLING > 1) ? $clog2(OVERSAMPLING) : 1;
  localparam int unsigned DCNT_W = $clog2(NDATA_BITS);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLING - 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(NDATA_BITS - 1);
  localparam logic              SCNT_LAST = 1'(NSTOP_BITS - 1);
  localparam logic              ODD_INV   = (PARITY_MODE == PARITY_ODD);

  uart_state_e           state_q, state_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [DCNT_W-1:0]     dcnt_q, dcnt_d;
  logic                  scnt_q, scnt_d;
  logic [NDATA_BITS-1:0] shreg_q, shreg_d;
  logic                  parity_q, parity_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic                  bit_end;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      dcnt_q   <= '0;
      scnt_q   <= 1'b0;
      shreg_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      dcnt_q   <= dcnt_d;
      scnt_q   <= scnt_d;
      shreg_q  <= shreg_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    dcnt_d   = dcnt_q;
    scnt_d   = scnt_q;
    shreg_d  = shreg_q;
    parity_d = parity_q;
    done_d   = 1'b0;
    bit_end  = 1'b0;
    tx_d     = 1'b1;

    // Bit timing runs only inside a frame; the counter is cleared on accept.
    if (state_q != IDLE && i_baud) begin
      if (tick_q == TICK_LAST) begin
        tick_d  = '0;
        bit_end = 1'b1;
      end else begin
        tick_d = tick_q + TICK_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (i_tx_start) begin
          shreg_d  = i_data;
          tick_d   = '0;
          parity_d = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          dcnt_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          parity_d = parity_q ^ shreg_q[0];
          shreg_d  = shreg_q >> 1;
          dcnt_d   = dcnt_q + DCNT_W'(1);
          if (dcnt_q == DCNT_LAST) begin
            if (PARITY_MODE != PARITY_NONE) begin
              state_d = PARITY;
            end else begin
              scnt_d  = 1'b0;
              state_d = STOP;
            end
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          scnt_d  = 1'b0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (scnt_q == SCNT_LAST) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The line is registered, so its next value follows the next state:
    // the bit a state drives appears on the same cycle the state is entered.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = parity_d ^ ODD_INV;
      default: tx_d = 1'b1;
    endcase
  end

  assign o_tx      = tx_q;
  assign o_busy    = (state_q != IDLE);
  assign o_tx_done = done_q;

endmodule
